// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: FSM state encoding and
// the width helper for the per-bit sample counter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StData    = 3'd2,
        StParity  = 3'd3,
        StStop    = 3'd4,
        StBrkWait = 3'd5
    } rx_state_t;

    function automatic int unsigned cnt_width(input int unsigned oversample);
        return (oversample < 2) ? 1 : $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line, followed by a
// three-sample history and a majority vote used for bit decisions.
module uart_rx_sync (
    input  logic baud_clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic vote
);

    logic       meta;
    logic [2:0] hist;

    // Everything resets to the idle line level so no false start is seen.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            hist <= 3'b111;
        end else begin
            meta <= rx;
            rx_s <= meta;
            hist <= {hist[1:0], rx_s};
        end
    end

    assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_rx_os.sv
// Parametrised oversampling UART receiver with glitch rejection, majority
// voting, parity/framing/overrun flags and a valid/ready output handshake.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 baud_clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned   CW        = cnt_width(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    logic                 rx_s;
    logic                 vote;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;
    logic                 mid;
    logic                 ferr_fin;
    logic                 deliver;

    uart_rx_sync u_sync (
        .baud_clk (baud_clk),
        .rst      (rst),
        .rx       (rx),
        .rx_s     (rx_s),
        .vote     (vote)
    );

    always_comb begin
        mid      = (cnt == CNT_MID);
        ferr_fin = ferr | ~vote;
        deliver  = (state == StStop) && mid && (stop_idx == LAST_STOP);
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    cnt <= '0;
                    if (!rx_s) state <= StStart;
                end
                StStart: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (vote) begin
                            state <= StIdle;
                        end else begin
                            state   <= StData;
                            bit_idx <= '0;
                            perr    <= 1'b0;
                            ferr    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    cnt <= mid ? '0 : cnt + 1'b1;
                    if (mid) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state    <= (PARITY_EN != 0) ? StParity : StStop;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                StParity: begin
                    cnt <= mid ? '0 : cnt + 1'b1;
                    if (mid) begin
                        perr  <= vote ^ (^shreg) ^ PARITY_ODD[0];
                        state <= StStop;
                    end
                end
                StStop: begin
                    cnt <= mid ? '0 : cnt + 1'b1;
                    if (mid) begin
                        ferr <= ferr_fin;
                        if (stop_idx == LAST_STOP) begin
                            // A low stop bit may be a break: wait for the line to recover.
                            state <= ferr_fin ? StBrkWait : StIdle;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                StBrkWait: begin
                    cnt <= '0;
                    if (rx_s) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (deliver) begin
            if (!dout_valid || dout_ready) begin
                dout       <= shreg;
                parity_err <= perr;
                frame_err  <= ferr_fin;
                dout_valid <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

    assign busy = (state != StIdle);

endmodule
